// File: rtl/sd_d_chk.sv
// rtl/sd_d_chk.sv - SD test-pattern receive checker: word compare, DP length and count
`timescale 1ns/1ps

`ifndef S_DP_LEN
`define S_DP_LEN 8
`endif
`ifndef S_DP_COUNT
`define S_DP_COUNT 3
`endif

module sd_d_chk #(
    parameter logic [15:0] INI_VAL  = 16'h0000,
    parameter int          DP_LEN   = `S_DP_LEN,
    parameter int          DP_COUNT = `S_DP_COUNT
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        chk_start,
    input  logic [7:0]  rx_d,
    input  logic        rx_d_vld,
    input  logic        rx_dp_sop,
    input  logic        rx_dp_eop,
    output logic        chk_busy,
    output logic        chk_done,
    output logic        chk_pass,
    output logic        word_err,
    output logic        len_err,
    output logic [15:0] err_cnt,
    output logic [7:0]  dp_left
);

    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_WAIT_SOP = 2'd1;
    localparam logic [1:0]  ST_RX_HI    = 2'd2;
    localparam logic [1:0]  ST_RX_LO    = 2'd3;
    localparam logic [15:0] LEN         = 16'(DP_LEN);
    localparam logic [7:0]  CNT         = 8'(DP_COUNT);

    logic [1:0]  state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] exp_q, exp_d;
    logic [15:0] cnt_q, cnt_d;
    logic        long_q, long_d;
    logic [7:0]  left_q, left_d;
    logic [15:0] err_q, err_d;
    logic        busy_q, busy_d;
    logic        pass_q, pass_d;
    logic        done_q, done_d;
    logic        word_err_q, word_err_d;
    logic        len_err_q, len_err_d;

    logic [1:0]  nerr;
    logic [15:0] cnt_nxt;
    logic [16:0] err_sum;
    logic        start_dp, close_dp, finish;

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        exp_d      = exp_q;
        cnt_d      = cnt_q;
        long_d     = long_q;
        left_d     = left_q;
        err_d      = err_q;
        busy_d     = busy_q;
        pass_d     = pass_q;
        done_d     = 1'b0;
        word_err_d = 1'b0;
        len_err_d  = 1'b0;
        nerr       = 2'd0;
        start_dp   = 1'b0;
        close_dp   = 1'b0;
        finish     = 1'b0;
        err_sum    = 17'd0;
        cnt_nxt    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

        if (chk_start) begin
            err_d   = 16'd0;
            pass_d  = 1'b0;
            left_d  = CNT;
            state_d = ST_WAIT_SOP;
            busy_d  = 1'b1;
            long_d  = 1'b0;
        end else if (rx_d_vld && state_q != ST_IDLE) begin
            case (state_q)
                ST_WAIT_SOP: begin
                    if (rx_dp_sop) begin
                        start_dp = 1'b1;
                    end else begin
                        len_err_d = 1'b1;
                        nerr      = nerr + 2'd1;
                    end
                end
                default: begin
                    if (rx_dp_sop) begin
                        // truncated DP: it still consumes one of the expected DPs
                        len_err_d = 1'b1;
                        nerr      = nerr + 2'd1;
                        left_d    = left_q - 8'd1;
                        if (left_q == 8'd1) begin
                            finish = 1'b1;
                        end else begin
                            start_dp = 1'b1;
                        end
                    end else begin
                        if (state_q == ST_RX_HI) begin
                            if ({hi_q, rx_d} != exp_q) begin
                                word_err_d = 1'b1;
                                nerr       = nerr + 2'd1;
                            end
                            exp_d   = exp_q + 16'd1;
                            state_d = ST_RX_LO;
                        end else begin
                            hi_d    = rx_d;
                            state_d = ST_RX_HI;
                        end
                        cnt_d = cnt_nxt;
                        // an over-length DP is reported once, on the first excess byte
                        if (rx_dp_eop) begin
                            close_dp = 1'b1;
                            if (!long_q && !(state_q == ST_RX_HI && cnt_nxt == LEN)) begin
                                len_err_d = 1'b1;
                                nerr      = nerr + 2'd1;
                            end
                        end else if (!long_q && cnt_q == LEN) begin
                            len_err_d = 1'b1;
                            nerr      = nerr + 2'd1;
                            long_d    = 1'b1;
                        end
                    end
                end
            endcase

            if (start_dp) begin
                exp_d   = INI_VAL;
                hi_d    = rx_d;
                cnt_d   = 16'd1;
                long_d  = 1'b0;
                state_d = ST_RX_HI;
                if (rx_dp_eop) begin
                    len_err_d = 1'b1;
                    nerr      = nerr + 2'd1;
                    close_dp  = 1'b1;
                end
            end

            if (close_dp) begin
                left_d = left_d - 8'd1;
                if (left_d == 8'd0) begin
                    finish = 1'b1;
                end else begin
                    state_d = ST_WAIT_SOP;
                end
            end

            err_sum = {1'b0, err_q} + {15'd0, nerr};
            err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];

            if (finish) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                pass_d  = (err_d == 16'd0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            hi_q       <= 8'd0;
            exp_q      <= INI_VAL;
            cnt_q      <= 16'd0;
            long_q     <= 1'b0;
            left_q     <= 8'd0;
            err_q      <= 16'd0;
            busy_q     <= 1'b0;
            pass_q     <= 1'b0;
            done_q     <= 1'b0;
            word_err_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            exp_q      <= exp_d;
            cnt_q      <= cnt_d;
            long_q     <= long_d;
            left_q     <= left_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            pass_q     <= pass_d;
            done_q     <= done_d;
            word_err_q <= word_err_d;
            len_err_q  <= len_err_d;
        end
    end

    assign chk_busy = busy_q;
    assign chk_done = done_q;
    assign chk_pass = pass_q;
    assign word_err = word_err_q;
    assign len_err  = len_err_q;
    assign err_cnt  = err_q;
    assign dp_left  = left_q;

endmodule

// File: tb/tb_sd_d_chk.sv
// tb/tb_sd_d_chk.sv - self-checking bench for sd_d_chk: vector table, directed corners, random vs model
`timescale 1ns/1ps

module tb_sd_d_chk;

    localparam logic [15:0] INI   = 16'h0000;
    localparam int          LEN   = 8;
    localparam int          COUNT = 3;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        chk_start = 1'b0;
    logic [7:0]  rx_d = 8'd0;
    logic        rx_d_vld = 1'b0;
    logic        rx_dp_sop = 1'b0;
    logic        rx_dp_eop = 1'b0;
    logic        chk_busy, chk_done, chk_pass, word_err, len_err;
    logic [15:0] err_cnt;
    logic [7:0]  dp_left;

    int errors = 0;
    int checks = 0;

    sd_d_chk #(.INI_VAL(INI), .DP_LEN(LEN), .DP_COUNT(COUNT)) dut (
        .clk(clk), .n_rst(n_rst), .chk_start(chk_start),
        .rx_d(rx_d), .rx_d_vld(rx_d_vld), .rx_dp_sop(rx_dp_sop), .rx_dp_eop(rx_dp_eop),
        .chk_busy(chk_busy), .chk_done(chk_done), .chk_pass(chk_pass),
        .word_err(word_err), .len_err(len_err), .err_cnt(err_cnt), .dp_left(dp_left)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: tracks the bytes of the current DP and judges by DP position
    bit          m_active, m_in_dp, m_busy, m_done, m_pass, m_we, m_le;
    logic [15:0] m_err;
    logic [7:0]  m_left;
    logic [7:0]  m_q[$];

    task automatic m_reset();
        m_active = 0; m_in_dp = 0; m_busy = 0; m_done = 0; m_pass = 0;
        m_we = 0; m_le = 0; m_err = 0; m_left = 0; m_q.delete();
    endtask

    task automatic m_start();
        m_active = 1; m_in_dp = 0; m_busy = 1; m_done = 0; m_pass = 0;
        m_we = 0; m_le = 0; m_err = 0; m_left = 8'(COUNT);
    endtask

    task automatic m_idle();
        m_done = 0; m_we = 0; m_le = 0;
    endtask

    task automatic m_byte(input logic [7:0] b, input bit sop, input bit eop);
        int nlen, nword, n, tot;
        bit do_start, close, fin;
        logic [15:0] w, ew;
        nlen = 0; nword = 0; do_start = 0; close = 0; fin = 0;
        m_idle();
        if (!m_active) return;
        if (!m_in_dp) begin
            if (sop) do_start = 1; else nlen++;
        end else if (sop) begin
            nlen++;
            m_left = m_left - 1;
            if (m_left == 0) fin = 1; else do_start = 1;
        end else begin
            m_q.push_back(b);
            n = m_q.size();
            if (n % 2 == 0) begin
                w  = {m_q[n-2], m_q[n-1]};
                ew = 16'(INI + (n / 2 - 1));
                if (w != ew) nword++;
            end
            if (eop) begin
                close = 1;
                if (n != LEN && n <= LEN + 1) nlen++;
            end else if (n == LEN + 1) begin
                nlen++;
            end
        end
        if (do_start) begin
            m_q.delete(); m_q.push_back(b); m_in_dp = 1;
            if (eop) begin nlen++; close = 1; end
        end
        if (close) begin
            m_in_dp = 0;
            m_left = m_left - 1;
            if (m_left == 0) fin = 1;
        end
        tot = int'(m_err) + nlen + nword;
        m_err = (tot > 65535) ? 16'hFFFF : 16'(tot);
        m_le = (nlen > 0);
        m_we = (nword > 0);
        if (fin) begin
            m_active = 0; m_in_dp = 0; m_busy = 0; m_done = 1; m_pass = (m_err == 0);
        end
    endtask

    task automatic check_out(input string nm);
        logic [28:0] act, exp;
        act = {chk_busy, chk_done, chk_pass, word_err, len_err, err_cnt, dp_left};
        exp = {m_busy, m_done, m_pass, m_we, m_le, m_err, m_left};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got busy=%0b done=%0b pass=%0b we=%0b le=%0b err=%0d left=%0d, want busy=%0b done=%0b pass=%0b we=%0b le=%0b err=%0d left=%0d",
                     nm, chk_busy, chk_done, chk_pass, word_err, len_err, err_cnt, dp_left,
                     m_busy, m_done, m_pass, m_we, m_le, m_err, m_left);
        end
    endtask

    task automatic check_val(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit sop, input bit eop, input string nm, input bit chk);
        rx_d = b; rx_dp_sop = sop; rx_dp_eop = eop; rx_d_vld = 1'b1;
        @(posedge clk); #1;
        rx_d_vld = 1'b0; rx_dp_sop = 1'b0; rx_dp_eop = 1'b0;
        m_byte(b, sop, eop);
        if (chk) check_out(nm);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            m_idle();
            check_out("gap");
        end
    endtask

    task automatic do_start(input bit with_byte);
        chk_start = 1'b1;
        if (with_byte) begin rx_d = 8'h00; rx_dp_sop = 1'b1; rx_d_vld = 1'b1; end
        @(posedge clk); #1;
        chk_start = 1'b0; rx_d_vld = 1'b0; rx_dp_sop = 1'b0;
        m_start();
        check_out("start");
    endtask

    function automatic logic [7:0] pat(input int i);
        logic [15:0] w;
        w = 16'(INI + i / 2);
        return (i % 2 == 0) ? w[15:8] : w[7:0];
    endfunction

    // sends an n-byte DP of the expected pattern; bad_i >= 0 replaces that byte with bad_v
    task automatic send_dp(input int n, input int bad_i, input logic [7:0] bad_v, input string nm);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = (i == bad_i) ? bad_v : pat(i);
            send(b, i == 0, i == n - 1, nm, 1);
        end
    endtask

    typedef struct {
        logic [7:0]  b;
        bit          sop, eop;
        bit          we, le, done, busy, pass;
        logic [15:0] err;
        logic [7:0]  left;
    } vec_t;

    vec_t vecs[24];
    int   le_seen;

    initial begin
        // clean DP, DP with word 1 = 0005, short DP ending on byte 6
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 8; i++) begin
                int r;
                r = d * 8 + i;
                vecs[r].b = pat(i);
                vecs[r].sop = (i == 0);
                vecs[r].eop = (d < 2) ? (i == 7) : (i == 5);
                vecs[r].we = 0; vecs[r].le = 0; vecs[r].done = 0; vecs[r].busy = 1; vecs[r].pass = 0;
                vecs[r].err = (d == 0 || (d == 1 && i < 3)) ? 16'd0 : 16'd1;
                vecs[r].left = 8'(3 - d - ((d < 2 && i == 7) ? 1 : 0));
            end
        end
        vecs[11].b = 8'h05; vecs[11].we = 1;
        vecs[21].eop = 1; vecs[21].le = 1; vecs[21].err = 2; vecs[21].left = 0;
        vecs[21].done = 1; vecs[21].busy = 0;

        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_out("reset");
        n_rst = 1'b1;
        gap(2);

        do_start(0);
        check_val("busy_after_start", 16'(chk_busy), 16'd1);
        for (int r = 0; r < 22; r++) begin
            logic [28:0] act, exp;
            send(vecs[r].b, vecs[r].sop, vecs[r].eop, "tbl", 0);
            act = {chk_busy, chk_done, chk_pass, word_err, len_err, err_cnt, dp_left};
            exp = {vecs[r].busy, vecs[r].done, vecs[r].pass, vecs[r].we, vecs[r].le, vecs[r].err, vecs[r].left};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL tbl[%0d]: got %h, want %h", r, act, exp);
            end
        end
        gap(1);
        check_val("tbl_pass_hold", 16'(chk_pass), 16'd0);

        // clean session
        do_start(0);
        for (int d = 0; d < 3; d++) send_dp(8, -1, 8'h00, "clean");
        check_val("clean_pass", 16'(chk_pass), 16'd1);
        check_val("clean_err", err_cnt, 16'd0);
        check_val("clean_left", 16'(dp_left), 16'd0);
        gap(2);
        check_val("pass_held", 16'(chk_pass), 16'd1);

        // long DP, odd-length DP, then a normal one
        do_start(0);
        le_seen = 0;
        for (int i = 0; i < 10; i++) begin
            send(pat(i), i == 0, i == 9, "long", 1);
            le_seen += int'(len_err);
        end
        check_val("long_len_pulses", 16'(le_seen), 16'd1);
        check_val("long_err", err_cnt, 16'd1);
        send_dp(7, -1, 8'h00, "odd");
        check_val("odd_err", err_cnt, 16'd2);
        send_dp(8, -1, 8'h00, "after_odd");
        check_val("odd_pass", 16'(chk_pass), 16'd0);

        // restart mid-DP, then stray byte
        do_start(0);
        send_dp(8, 3, 8'h07, "pre_restart");
        for (int i = 0; i < 3; i++) send(pat(i), i == 0, 0, "dp2_part", 1);
        do_start(0);
        check_val("restart_err", err_cnt, 16'd0);
        check_val("restart_left", 16'(dp_left), 16'd3);
        send(8'h55, 0, 0, "stray", 1);
        check_val("stray_len", 16'(len_err), 16'd1);
        // truncated DP (sop mid-DP), and a 1-byte DP
        send(pat(0), 1, 0, "t0", 1);
        send(pat(1), 0, 0, "t1", 1);
        send(pat(0), 1, 0, "trunc", 1);
        send(8'h00, 1, 1, "one_byte", 1);

        // chk_start wins over a byte in the same cycle
        do_start(1);
        send(8'h00, 0, 0, "prio_stray", 1);

        // reset mid-session, then traffic in IDLE is ignored
        send_dp(8, 1, 8'hAA, "pre_reset");
        send(pat(0), 1, 0, "pre_reset2", 1);
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        m_reset();
        check_out("mid_reset");
        send(8'h12, 1, 0, "idle_ign", 1);
        send(8'h34, 0, 1, "idle_ign", 1);

        // random sessions against the model
        for (int s = 0; s < 14; s++) begin
            do_start(0);
            for (int d = 0; d < 8 && m_active; d++) begin
                int n;
                if ($urandom_range(0, 5) == 0) send(8'($urandom), 0, 1'($urandom_range(0, 1)), "rnd_stray", 1);
                n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : LEN;
                for (int i = 0; i < n; i++) begin
                    logic [7:0] b;
                    bit eop;
                    b = pat(i);
                    if ($urandom_range(0, 15) == 0) b = b ^ 8'($urandom_range(1, 255));
                    eop = (i == n - 1) && ($urandom_range(0, 7) != 0);
                    send(b, i == 0, eop, "rnd", 1);
                    if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
                end
                if ($urandom_range(0, 30) == 0) do_start(0);
            end
        end

        // error counter saturation via stray bytes
        do_start(0);
        for (int i = 0; i < 70000; i++) send(8'h5A, 0, 0, "sat", 0);
        check_out("sat");
        check_val("sat_err", err_cnt, 16'hFFFF);
        send(8'h5A, 0, 0, "sat_more", 1);
        check_val("sat_hold", err_cnt, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
